// File: rtl/cmp_access_sched.sv
// cmp_access_sched
// Arbitrates a shared constant-time secret comparator between two requesters
// and enforces a per-requester timed lockout after repeated mismatches.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid[i]  requester i has a candidate word to compare
//   req_data      candidate words, requester i on [i*8*NBYTES +: 8*NBYTES]
//   req_ready[i]  one-hot grant, only ever asserted in IDLE
//   secret_value  reference secret, sampled at accept
//   rsp_valid[i]  one-cycle response pulse to the granted requester
//   rsp_match     compare result, 0 whenever rsp_valid is 0
//   locked[i]     requester i is locked out
//
// FSM states
//   state | meaning
//   IDLE  | arbitrate eligible requesters, capture winner on accept
//   CMP   | fold one byte per cycle into diff, always NBYTES cycles
//   RESP  | response pulse visible, fail counter / lockout update
module cmp_access_sched #(
   parameter int NBYTES      = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   input  logic [2*8*NBYTES-1:0]   req_data,
   output logic [1:0]              req_ready,
   input  logic [8*NBYTES-1:0]     secret_value,
   output logic [1:0]              rsp_valid,
   output logic                    rsp_match,
   output logic [1:0]              locked
);

   localparam int             W    = 8 * NBYTES;
   localparam int             IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0]  LAST = IW'(NBYTES - 1);
   localparam logic [3:0]     MF   = 4'(MAX_FAIL);
   localparam logic [15:0]    LC   = 16'(LOCK_CYCLES);

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   state_t          state;
   logic            rr_ptr;      // 1: requester 1 wins a tie
   logic            win_id;
   logic [W-1:0]    cand_q;
   logic [W-1:0]    sec_q;
   logic [7:0]      diff;
   logic [IW-1:0]   idx;
   logic [3:0]      fail_cnt   [2];
   logic [15:0]     lock_timer [2];

   logic [1:0]      elig;
   logic [1:0]      grant;
   logic [7:0]      byte_diff;
   logic [7:0]      diff_next;

   always_comb begin
      elig  = req_valid & ~locked;
      grant = 2'b00;
      if (elig == 2'b11)
         grant = rr_ptr ? 2'b10 : 2'b01;
      else
         grant = elig;
      // Gating with rst keeps every output low while reset is held.
      req_ready = (state == IDLE && !rst) ? grant : 2'b00;
      // Byte select is a plain mux on idx: no data-dependent control.
      byte_diff = cand_q[idx*8 +: 8] ^ sec_q[idx*8 +: 8];
      diff_next = diff | byte_diff;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         win_id    <= 1'b0;
         cand_q    <= '0;
         sec_q     <= '0;
         diff      <= '0;
         idx       <= '0;
         rsp_valid <= 2'b00;
         rsp_match <= 1'b0;
         locked    <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            fail_cnt[i]   <= '0;
            lock_timer[i] <= '0;
         end
      end else begin
         rsp_valid <= 2'b00;
         rsp_match <= 1'b0;

         for (int i = 0; i < 2; i++) begin
            if (locked[i]) begin
               if (lock_timer[i] == 16'd1) begin
                  locked[i]     <= 1'b0;
                  lock_timer[i] <= '0;
                  fail_cnt[i]   <= '0;
               end else begin
                  lock_timer[i] <= lock_timer[i] - 16'd1;
               end
            end
         end

         case (state)
            IDLE: begin
               if (|req_ready) begin
                  win_id <= grant[1];
                  cand_q <= grant[1] ? req_data[W +: W] : req_data[0 +: W];
                  sec_q  <= secret_value;
                  rr_ptr <= ~grant[1];
                  diff   <= '0;
                  idx    <= '0;
                  state  <= CMP;
               end
            end
            CMP: begin
               diff <= diff_next;
               if (idx == LAST) begin
                  state     <= RESP;
                  rsp_valid <= win_id ? 2'b10 : 2'b01;
                  rsp_match <= (diff_next == 8'd0);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               // The granted requester was unlocked at accept, so this never
               // collides with the lock-timer update above.
               if (rsp_match) begin
                  fail_cnt[win_id] <= '0;
               end else if (fail_cnt[win_id] + 4'd1 == MF) begin
                  fail_cnt[win_id]   <= MF;
                  locked[win_id]     <= 1'b1;
                  lock_timer[win_id] <= LC;
               end else begin
                  fail_cnt[win_id] <= fail_cnt[win_id] + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_access_sched.sv
module tb_cmp_access_sched;

   localparam int NB = 4;
   localparam int MF = 3;
   localparam int LC = 64;
   localparam int W  = 8 * NB;
   localparam logic [W-1:0] S = 32'hA5A5_1234;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid;
   logic [2*W-1:0]  req_data;
   logic [1:0]      req_ready;
   logic [W-1:0]    secret_value;
   logic [1:0]      rsp_valid;
   logic            rsp_match;
   logic [1:0]      locked;

   cmp_access_sched #(.NBYTES(NB), .MAX_FAIL(MF), .LOCK_CYCLES(LC)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .secret_value (secret_value),
      .rsp_valid    (rsp_valid),
      .rsp_match    (rsp_match),
      .locked       (locked)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Transaction-level reference: a busy countdown per compare, whole-word
   // equality decided at accept, remaining lockout cycles per requester.
   int  m_busy;
   int  m_id;
   bit  m_match;
   int  m_ptr;
   int  m_fail [2];
   int  m_lock [2];

   logic [1:0] last_ready, last_rv, last_locked;
   logic       last_rm;
   int         last_cyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s cycle %0d: timed out waiting for DUT", name, cyc);
   endtask

   // Called just after a negedge with inputs already set: compare DUT against
   // the model, advance the model across the coming posedge, wait next negedge.
   task automatic tick();
      logic [1:0] elig, gnt, ev, el;
      logic       em;
      int         w;
      #1;
      elig = 2'b00;
      gnt  = 2'b00;
      for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (m_lock[i] == 0);
      if (!rst && m_busy == 0) begin
         if (elig == 2'b11) gnt = (m_ptr == 0) ? 2'b01 : 2'b10;
         else               gnt = elig;
      end
      ev = (!rst && m_busy == 1) ? ((m_id == 0) ? 2'b01 : 2'b10) : 2'b00;
      em = (!rst && m_busy == 1) ? m_match : 1'b0;
      el = rst ? 2'b00 : {m_lock[1] > 0, m_lock[0] > 0};
      chk("req_ready", 32'(req_ready), 32'(gnt));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_match", 32'(rsp_match), 32'(em));
      chk("locked",    32'(locked),    32'(el));
      last_ready  = req_ready;
      last_rv     = rsp_valid;
      last_rm     = rsp_match;
      last_locked = locked;
      last_cyc    = cyc;

      if (rst) begin
         m_busy = 0; m_ptr = 0; m_id = 0; m_match = 0;
         for (int i = 0; i < 2; i++) begin m_fail[i] = 0; m_lock[i] = 0; end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_lock[i] > 0) begin
               m_lock[i]--;
               if (m_lock[i] == 0) m_fail[i] = 0;
            end
         end
         if (m_busy == 1) begin
            if (m_match) m_fail[m_id] = 0;
            else begin
               m_fail[m_id]++;
               if (m_fail[m_id] == MF) m_lock[m_id] = LC;
            end
            m_busy = 0;
         end else if (m_busy > 1) begin
            m_busy--;
         end else if (gnt != 2'b00) begin
            w       = gnt[1] ? 1 : 0;
            m_id    = w;
            m_match = (req_data[w*W +: W] == secret_value);
            m_ptr   = 1 - w;
            m_busy  = NB + 1;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_match, locked}), 32'd0);
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_rsp(input int id, input int t0, output int lat, output logic m);
      int t1;
      t1 = -1; lat = -1; m = 1'b0;
      for (int k = 0; k < 50 && t1 < 0; k++) begin
         tick();
         if (last_rv[id]) begin t1 = last_cyc; m = last_rm; end
      end
      if (t1 < 0) timeout("rsp_wait");
      else lat = t1 - t0;
   endtask

   task automatic send(input int id, input logic [W-1:0] val, output int lat, output logic m);
      int t0;
      t0 = -1; lat = -1; m = 1'b0;
      req_data[id*W +: W] = val;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 300 && t0 < 0; k++) begin
         tick();
         if (last_ready[id]) t0 = last_cyc;
      end
      req_valid[id] = 1'b0;
      if (t0 < 0) timeout("accept_wait");
      else wait_rsp(id, t0, lat, m);
   endtask

   typedef struct {
      int           id;
      logic [W-1:0] secret;
      logic [W-1:0] cand;
      bit           exp_match;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int   lat, t, lk, prev;
      logic m;
      logic [W-1:0] bad;

      vecs[0] = '{0, 32'hA5A5_1234, 32'hA5A5_1234, 1'b1};
      vecs[1] = '{0, 32'hA5A5_1234, 32'hA5A5_1235, 1'b0};
      vecs[2] = '{0, 32'hA5A5_1234, 32'h25A5_1234, 1'b0};
      vecs[3] = '{1, 32'hA5A5_1234, 32'hA5A5_1234, 1'b1};
      vecs[4] = '{1, 32'hDEAD_BEEF, 32'hDEAE_BEEF, 1'b0};
      vecs[5] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[6] = '{0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};

      rst = 1'b1;
      req_valid = 2'b00;
      req_data = '0;
      secret_value = '0;
      @(negedge clk);

      // Single transactions: fixed latency regardless of mismatch position.
      foreach (vecs[v]) begin
         do_reset();
         secret_value = vecs[v].secret;
         send(vecs[v].id, vecs[v].cand, lat, m);
         chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(NB + 1));
         chk($sformatf("vec%0d_match", v), 32'(m), 32'(vecs[v].exp_match));
      end

      // Both requesters held: grants alternate every NB+2 cycles, secret
      // scrambled during CMP must not affect the result.
      do_reset();
      secret_value = S;
      req_data = {S, S};
      req_valid = 2'b11;
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         t = -1;
         for (int j = 0; j < 20 && t < 0; j++) begin
            tick();
            if (|last_ready) t = last_cyc;
         end
         if (t < 0) begin timeout("alt_accept"); break; end
         chk($sformatf("alt%0d_grant", k), 32'(last_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         if (prev >= 0) chk($sformatf("alt%0d_spacing", k), 32'(t - prev), 32'(NB + 2));
         prev = t;
         for (int j = 0; j < NB; j++) begin
            secret_value = $urandom;
            tick();
         end
         secret_value = S;
         tick();
         chk($sformatf("alt%0d_rsp", k), 32'({last_rv, last_rm}), (k % 2 == 0) ? 32'd3 : 32'd5);
      end
      req_valid = 2'b00;

      // Requester 1 lockout while requester 0 keeps being served.
      do_reset();
      secret_value = S;
      for (int k = 0; k < MF; k++) begin
         send(1, S ^ 32'h0100_0000, lat, m);
         chk("lock_miss_match", 32'(m), 32'd0);
      end
      tick();
      lk = last_cyc;
      chk("lock_set", 32'(last_locked), 32'd2);
      send(0, S, lat, m);
      chk("lock_other_served", 32'({lat[7:0], m}), 32'({8'(NB + 1), 1'b1}));
      req_data[W +: W] = S;
      req_valid[1] = 1'b1;
      t = -1;
      for (int k = 0; k < 200 && t < 0; k++) begin
         tick();
         if (last_ready[1]) t = last_cyc;
      end
      req_valid[1] = 1'b0;
      if (t < 0) timeout("unlock_accept");
      else begin
         chk("unlock_delay", 32'(t - lk), 32'(LC));
         wait_rsp(1, t, lat, m);
         chk("unlock_match", 32'(m), 32'd1);
      end

      // Match clears the fail counter; the third consecutive miss locks.
      do_reset();
      secret_value = S;
      bad = S ^ 32'h0000_8000;
      send(0, bad, lat, m);
      send(0, bad, lat, m);
      send(0, S, lat, m);
      chk("clear_match", 32'(m), 32'd1);
      send(0, bad, lat, m);
      send(0, bad, lat, m);
      tick();
      chk("clear_no_lock", 32'(last_locked), 32'd0);
      send(0, bad, lat, m);
      tick();
      chk("third_miss_lock", 32'(last_locked), 32'd1);

      // Reset in the middle of a compare.
      do_reset();
      secret_value = S;
      for (int k = 0; k < MF; k++) send(1, ~S, lat, m);
      req_data[0 +: W] = S;
      req_valid[0] = 1'b1;
      t = -1;
      for (int k = 0; k < 20 && t < 0; k++) begin
         tick();
         if (last_ready[0]) t = last_cyc;
      end
      req_valid[0] = 1'b0;
      if (t < 0) timeout("rst_accept");
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_outputs", 32'({last_ready, last_rv, last_rm, last_locked}), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < NB + 2; k++) tick();
      send(0, S, lat, m);
      chk("post_rst_latency", 32'(lat), 32'(NB + 1));
      chk("post_rst_match", 32'(m), 32'd1);

      // Randomized traffic checked cycle by cycle against the model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(499, 0) == 0);
         req_valid = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            case ($urandom_range(3, 0))
               0, 1:    req_data[i*W +: W] = secret_value;
               2:       req_data[i*W +: W] = secret_value ^ (32'h1 << $urandom_range(31, 0));
               default: req_data[i*W +: W] = $urandom;
            endcase
         end
         if ($urandom_range(15, 0) == 0) secret_value = $urandom;
         tick();
      end
      rst = 1'b0;
      req_valid = 2'b00;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_access_sched.md
Name: cmp_access_sched

Overview:
- Schedules a shared multi-byte secret comparator between two requesters, for example a debug-unlock port and a firmware mailbox.
- Enforces constant-time comparison: the latency is identical whatever the mismatch position or secret contents. This is the CWE-203 mitigation.
- Tracks failed attempts per requester and enforces a timed lockout.
- Sits between the requester interfaces and the secret-holding register file.

Parameters:
- NBYTES, 4, number of bytes in the secret and candidate words.
- MAX_FAIL, 3, consecutive mismatches that trigger lockout of a requester (range 1..15).
- LOCK_CYCLES, 64, lockout duration in clk cycles (range 1..65535).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester compare request.
- req_data  in  2*8*NBYTES  candidate words. Requester i drives bits [i*8*NBYTES +: 8*NBYTES].
- req_ready  out  2  one-hot grant. Accept happens when req_valid[i] && req_ready[i].
- secret_value  in  8*NBYTES  reference secret.
- rsp_valid  out  2  one-hot, 1-cycle response pulse to the requester that was granted.
- rsp_match  out  1  compare result. Qualified by |rsp_valid and forced 0 otherwise.
- locked  out  2  requester i is in lockout.

Behaviour:
- Reset (async, immediate): all outputs 0, FSM=IDLE, round-robin pointer favours requester 0, fail counters 0, lock timers 0, capture registers 0.
  - A reset mid-compare aborts the compare with no response.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - Eligible requester i means req_valid[i] && !locked[i].
  - Grant is combinational: req_ready is asserted for exactly one eligible requester, chosen by round-robin; the pointer favours the requester not granted last.
  - No eligible requester: req_ready=0.
  - req_ready is never asserted outside IDLE.
  - On accept: capture req_data of the winner and secret_value into internal registers, record the winner id, update the pointer, clear the diff accumulator, clear the byte index, go to CMP.
- CMP:
  - One byte per cycle, LSB byte first: diff |= cand_byte ^ secret_byte.
  - Always exactly NBYTES cycles, with no early exit on mismatch.
  - Changes to secret_value or req_data after capture have no effect.
  - After byte NBYTES-1 go to RESP.
- RESP:
  - rsp_valid[id]=1 and rsp_match=(diff==0) for one cycle, then IDLE.
  - Latency: accept at cycle T gives rsp_valid at T+NBYTES+1. Fixed.
  - Back-to-back: the next grant can happen in the IDLE cycle that follows RESP, so the throughput is one compare per NBYTES+2 cycles.
- Fail counter, per requester (4 bits):
  - Updated in the RESP cycle.
  - Match: clear to 0.
  - Mismatch: increment. On reaching MAX_FAIL, set locked[id], load lock_timer[id]=LOCK_CYCLES, and hold the counter.
- Lock timer, per requester (16 bits):
  - Decrements each cycle while locked.
  - When the timer is 1, the next cycle sees locked=0, timer=0 and fail counter=0.
  - Requester i is eligible again in the first cycle where locked[i]=0.
  - The two requesters lock and unlock independently. A locked requester does not block the other one.
- Simultaneous events:
  - Both requesters valid and eligible: the pointer decides.
  - req_valid dropped before grant: no effect.
  - req_valid held through CMP/RESP: the request is re-arbitrated in the next IDLE.
- No timing-dependent path: state sequence, cycle count and req_ready timing are identical for match and mismatch, apart from the rsp_match value and any later lockout.

Test Plan:
- NBYTES=4, secret 0xA5A5_1234, requester 0 sends 0xA5A5_1234 at T=10 -> rsp_valid=2'b01, rsp_match=1 at T=15; fail counter stays 0.
- Mismatch in byte 0 (0xA5A5_1235) vs mismatch in byte 3 (0x25A5_1234) -> both give rsp_valid at T+5 with rsp_match=0; identical req_ready/rsp_valid waveforms.
- Both req_valid held high continuously -> grants alternate 0,1,0,1, each response 6 cycles apart; secret_value toggled during CMP does not alter rsp_match.
- Requester 1 sends 3 consecutive mismatches -> locked=2'b10 after the third RESP, req_ready[1]=0 for 64 cycles while requester 0 is still served; then locked clears and a correct value returns rsp_match=1.
- Two mismatches then a match from requester 0 -> counter clears; two further mismatches do not lock.
- rst asserted mid-CMP -> outputs 0 immediately, no rsp_valid, locked cleared; the next request completes normally with fixed latency.
